piece_dispenser: RTL and testbench

PIECE_DISPENSER -- requirements
Module: piece_dispenser

---
 rtl/piece_dispenser.sv | 160 ++++++++++++++++
 tb/tb_piece_dispenser.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_dispenser.sv
// piece_dispenser
// Two-deep bag buffer between a 7-piece bag generator and a piece consumer.
// The "cur" buffer is dispensed slot by slot while the "nxt" buffer is
// refilled in the background by a small fetch FSM, so the consumer sees no
// bubble at a bag boundary as long as the generator keeps up.
// Optional look-ahead outputs (next_valid / next_piece) are built only when
// the macro PIECE_PREVIEW_EN is defined.
module piece_dispenser (
   input  logic        clk,
   input  logic        nreset,
   output logic        newbag,
   input  logic        bag_ready,
   input  logic [20:0] bag_pieces,
   output logic        piece_valid,
   output logic [2:0]  piece,
   input  logic        piece_take,
`ifdef PIECE_PREVIEW_EN
   output logic        next_valid,
   output logic [2:0]  next_piece,
`endif
   output logic        bag_err
);

   // Fetch FSM encoding.
   localparam logic [1:0] F_IDLE  = 2'd0;
   localparam logic [1:0] F_REQ   = 2'd1;
   localparam logic [1:0] F_GUARD = 2'd2;
   localparam logic [1:0] F_WAIT  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_next;

   logic [20:0] r_cur;
   logic [2:0]  r_idx;
   logic [3:0]  r_cnt;

   logic [20:0] r_nxt;
   logic        r_nxt_full;

   logic        r_bag_err;

   logic        w_capture;
   logic        w_xfer;
   logic        w_load;

   // Select one 3-bit code out of a packed 7-slot bag; slot 0 sits in the LSBs.
   function automatic logic [2:0] slot_of(input logic [20:0] bag, input logic [2:0] idx);
      case (idx)
         3'd0:    return bag[2:0];
         3'd1:    return bag[5:3];
         3'd2:    return bag[8:6];
         3'd3:    return bag[11:9];
         3'd4:    return bag[14:12];
         3'd5:    return bag[17:15];
         3'd6:    return bag[20:18];
         default: return 3'd0;
      endcase
   endfunction

   // True when any slot of the bag carries the illegal code 7.
   function automatic logic has_seven(input logic [20:0] bag);
      logic found;
      found = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (bag[3*k +: 3] == 3'd7) found = 1'b1;
      end
      return found;
   endfunction

   // A capture happens only while waiting; the guard cycle before it masks a
   // ready level that is still left over from the previous bag.
   assign w_capture = (r_state == F_WAIT) && bag_ready;

   // A consumer handshake only counts while a piece is actually on offer.
   assign w_xfer = piece_valid && piece_take;

   // Refill cur from nxt when cur is empty, or on the very edge that takes
   // the last piece of cur so the consumer never sees an empty cycle.
   assign w_load = r_nxt_full && ((r_cnt == 4'd0) || (w_xfer && (r_cnt == 4'd1)));

   // Next-state logic of the fetch FSM.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         F_IDLE:  if (!r_nxt_full) w_state_next = F_REQ;
         F_REQ:   w_state_next = F_GUARD;
         F_GUARD: w_state_next = F_WAIT;
         F_WAIT:  if (bag_ready) w_state_next = F_IDLE;
         default: w_state_next = F_IDLE;
      endcase
   end

   // Fetch FSM state register; reset abandons any fetch in progress.
   always_ff @(posedge clk or negedge nreset) begin
      // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
      if (!nreset) r_state <= F_IDLE;
      else         r_state <= w_state_next;
   end

   // The request pulse is exactly the one cycle spent in F_REQ.
   assign newbag = (r_state == F_REQ);

   // Current bag: dispense slot by slot, or reload from nxt.
   always_ff @(posedge clk or negedge nreset) begin
      // NOTE: the bag buffers are plain flops and are reset too, so piece reads 0 while in reset.
      if (!nreset) begin
         r_cur <= '0;
         r_idx <= '0;
         r_cnt <= '0;
      end else if (w_load) begin
         r_cur <= r_nxt;
         r_idx <= 3'd0;
         r_cnt <= 4'd7;
      end else if (w_xfer) begin
         r_idx <= r_idx + 3'd1;
         r_cnt <= r_cnt - 4'd1;
      end
   end

   // Next bag: a capture wins over the drain caused by a simultaneous load,
   // so the load takes the old contents and the new bag stays queued.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_nxt      <= '0;
         r_nxt_full <= 1'b0;
      end else if (w_capture) begin
         r_nxt      <= bag_pieces;
         r_nxt_full <= 1'b1;
      end else if (w_load) begin
         r_nxt_full <= 1'b0;
      end
   end

   // Sticky error flag for any captured bag holding code 7; only reset clears it.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)                             r_bag_err <= 1'b0;
      else if (w_capture && has_seven(bag_pieces)) r_bag_err <= 1'b1;
   end

   assign piece_valid = (r_cnt != 4'd0);
   assign piece       = slot_of(r_cur, r_idx);
   assign bag_err     = r_bag_err;

`ifdef PIECE_PREVIEW_EN
   // Look-ahead: the following slot of cur, or slot 0 of nxt at the bag boundary.
   always_comb begin
      next_valid = 1'b0;
      next_piece = 3'd0;
      if (r_cnt >= 4'd2) begin
         next_valid = 1'b1;
         next_piece = slot_of(r_cur, r_idx + 3'd1);
      end else if ((r_cnt == 4'd1) && r_nxt_full) begin
         next_valid = 1'b1;
         next_piece = r_nxt[2:0];
      end
   end
`endif

endmodule

// File: tb/tb_piece_dispenser.sv
// tb_piece_dispenser
// Bench for piece_dispenser. A generator process answers each newbag pulse
// and pushes the delivered pieces into a FIFO model; a monitor pops and
// compares on every piece transfer. Directed sections check reset, latency,
// bag-boundary continuity, reset in mid-fetch and the sticky error flag.
// Preview checks are compiled in when PIECE_PREVIEW_EN is defined.
module tb_piece_dispenser;

   logic        clk;
   logic        nreset;
   logic        newbag;
   logic        bag_ready;
   logic [20:0] bag_pieces;
   logic        piece_valid;
   logic [2:0]  piece;
   logic        piece_take;
   logic        bag_err;
`ifdef PIECE_PREVIEW_EN
   logic        next_valid;
   logic [2:0]  next_piece;
`endif

   piece_dispenser dut (
      .clk         (clk),
      .nreset      (nreset),
      .newbag      (newbag),
      .bag_ready   (bag_ready),
      .bag_pieces  (bag_pieces),
      .piece_valid (piece_valid),
      .piece       (piece),
      .piece_take  (piece_take),
`ifdef PIECE_PREVIEW_EN
      .next_valid  (next_valid),
      .next_piece  (next_piece),
`endif
      .bag_err     (bag_err)
   );

   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference model: every piece of every delivered bag, in dispense order.
   logic [2:0]  exp_q[$];
   logic [2:0]  exp_pc;
   int          nb_count       = 0;
   int          bags_presented = 0;
   logic        prev_nb;

   // Generator configuration driven by the main sequence.
   int          cfg_delay = 0;   // <0: random 0..2 extra wait cycles
   logic        cfg_fixed = 1'b1;
   logic [20:0] fixed_bag = '0;

   int          gen_wait;
   int          gen_delay;
   logic [20:0] gen_bag;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [20:0] random_bag();
      logic [20:0] b;
      b = '0;
      for (int k = 0; k < 7; k++) b[3*k +: 3] = 3'($urandom_range(6));
      return b;
   endfunction

   // Bag generator: sees newbag in the request cycle, keeps its old (stale)
   // ready/data through the guard cycle, then presents the new bag after
   // gen_delay further cycles and holds it until the next request.
   initial begin
      bag_ready  = 1'b0;
      bag_pieces = '0;
      gen_wait   = 0;
      gen_delay  = 0;
      gen_bag    = '0;
      forever begin
         @(posedge clk); #1;
         if (!nreset) begin
            gen_wait  = 0;
            bag_ready = 1'b0;
         end else if (gen_wait > 0) begin
            gen_wait--;
            if (gen_wait == 0) begin
               bag_pieces = gen_bag;
               bag_ready  = 1'b1;
               bags_presented++;
               for (int k = 0; k < 7; k++) exp_q.push_back(gen_bag[3*k +: 3]);
            end else if (gen_wait <= gen_delay) begin
               bag_ready = 1'b0;
            end
         end else if (newbag) begin
            gen_delay = (cfg_delay < 0) ? int'($urandom_range(2)) : cfg_delay;
            gen_bag   = cfg_fixed ? fixed_bag : random_bag();
            gen_wait  = gen_delay + 2;
         end
      end
   end

   // Monitor: newbag pulse width and the dispensed piece stream.
   initial begin
      prev_nb = 1'b0;
      forever begin
         @(negedge clk);
         if (nreset) begin
            if (newbag) begin
               nb_count++;
               check("newbag_one_cycle", prev_nb, 0);
            end
            prev_nb = newbag;
            if (piece_valid && piece_take) begin
               check("xfer_queue_nonempty", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  exp_pc = exp_q.pop_front();
                  check("piece", piece, exp_pc);
               end
            end
         end else begin
            prev_nb = 1'b0;
         end
      end
   end

   // One clock cycle: input changes just after the edge, return just after the falling edge.
   task automatic step(input logic take);
      @(posedge clk); #2;
      piece_take = take;
      @(negedge clk); #1;
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      exp_q.delete();
      nb_count       = 0;
      bags_presented = 0;
      #1;
   endtask

   initial begin
      nreset     = 1'b0;
      piece_take = 1'b0;
      cfg_delay  = 0;
      cfg_fixed  = 1'b1;
      fixed_bag  = 21'o6543210;

      // Reset values, before any clock edge.
      #3;
      check("rst_newbag", newbag, 0);
      check("rst_valid", piece_valid, 0);
      check("rst_piece", piece, 0);
      check("rst_bag_err", bag_err, 0);
      repeat (3) step(1'b0);

      // First fetch after release: request in cycle 1, capture at end of
      // cycle 3, first piece valid in cycle 5. Takes while invalid are ignored.
      nreset = 1'b1;
      step(1'b1);
      check("c1_newbag", newbag, 1);
      step(1'b1);
      check("c2_newbag", newbag, 0);
      step(1'b1);
      check("c3_valid", piece_valid, 0);
      step(1'b1);
      check("c4_valid", piece_valid, 0);
      step(1'b0);
      check("c5_valid", piece_valid, 1);
      check("c5_piece", piece, 0);
      check("c5_newbag_count", nb_count, 1);
      repeat (7) step(1'b0);
      check("c12_newbag_count", nb_count, 2);
      check("c12_bags", bags_presented, 2);
      check("c12_valid", piece_valid, 1);
      check("c12_piece", piece, 0);
      check("c12_depth", exp_q.size(), 14);
`ifdef PIECE_PREVIEW_EN
      check("c12_next_valid", next_valid, 1);
      check("c12_next_piece", next_piece, 1);
`endif

      // Continuous takes across two bag boundaries; generator answers in 0..2 extra cycles.
      cfg_delay = -1;
      for (int i = 0; i < 14; i++) begin
         step(1'b1);
         check("stream_valid", piece_valid, 1);
         check("stream_piece", piece, i % 7);
`ifdef PIECE_PREVIEW_EN
         check("stream_next_valid", next_valid, 1);
         check("stream_next_piece", next_piece, (i % 7 + 1) % 7);
`endif
      end

      // Randomized bags, delays and consumer; stale ready stays up through guard.
      cfg_fixed = 1'b0;
      repeat (400) step(1'($urandom_range(1)));
      repeat (20) step(1'b0);
      check("settle_valid", piece_valid, 1);
      check("settle_depth", (exp_q.size() >= 8) && (exp_q.size() <= 14), 1);
      check("settle_newbag_vs_bags", nb_count, bags_presented);
      check("settle_bag_err", bag_err, 0);

      // Reset while a fetch is waiting and cur holds 3 pieces.
      do_reset();
      step(1'b0);
      step(1'b0);
      cfg_fixed = 1'b1;
      fixed_bag = 21'o5555555;
      cfg_delay = 0;
      nreset    = 1'b1;
      step(1'b0);
      cfg_delay = 20;
      repeat (3) step(1'b0);
      repeat (4) step(1'b1);
      step(1'b0);
      check("wait_valid", piece_valid, 1);
      check("wait_piece", piece, 5);
      check("wait_depth", exp_q.size(), 3);
      check("wait_newbag", newbag, 0);
      fixed_bag = 21'o1111111;
      do_reset();
      check("mid_rst_newbag", newbag, 0);
      check("mid_rst_valid", piece_valid, 0);
      check("mid_rst_piece", piece, 0);
      check("mid_rst_bag_err", bag_err, 0);
      cfg_delay = 0;
      step(1'b0);
      step(1'b0);
      nreset = 1'b1;
      step(1'b0);
      check("post_rst_newbag", newbag, 1);
      repeat (30) step(1'($urandom_range(1)));
      check("post_rst_newbag_vs_bags", nb_count, bags_presented);

      // Bag with an illegal code 7 in slot 6: sticky flag, code passes through.
      do_reset();
      step(1'b0);
      step(1'b0);
      fixed_bag = 21'o7000000;
      cfg_delay = 0;
      nreset    = 1'b1;
      step(1'b0);
      fixed_bag = 21'o1234564;
      repeat (3) step(1'b0);
      check("err_set", bag_err, 1);
      for (int i = 0; i < 7; i++) begin
         step(1'b1);
         if (i == 0) check("err_first_piece", piece, 0);
         if (i == 6) begin
            check("err_last_piece", piece, 7);
`ifdef PIECE_PREVIEW_EN
            check("boundary_next_valid", next_valid, 1);
            check("boundary_next_piece", next_piece, 4);
`endif
         end
      end
      step(1'b0);
      check("err_sticky", bag_err, 1);
      check("err_next_bag_piece", piece, 4);
      check("err_next_bag_valid", piece_valid, 1);
      do_reset();
      check("err_cleared", bag_err, 0);
      step(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
